// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath mux selects and the branch-condition helper.
package rv_ctrl_pkg;

    typedef enum logic [4:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StJalrLink,
        StLui,
        StAuipc,
        StTrap
    } ctrl_state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;

    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpFunct  = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    // ALU computes rs1-rs2 (zero) or the SLT/SLTU outcome (alu_lsb) per funct3.
    function automatic logic branch_taken(logic [2:0] funct3, logic zero, logic alu_lsb);
        logic taken;
        case (funct3)
            3'b000:         taken = zero;
            3'b001:         taken = !zero;
            3'b100, 3'b110: taken = alu_lsb;
            3'b101, 3'b111: taken = !alu_lsb;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic branch_f3_legal(logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

    function automatic logic [2:0] imm_sel(logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OpStore:        sel = ImmS;
            OpBranch:       sel = ImmB;
            OpLui, OpAuipc: sel = ImmU;
            OpJal:          sel = ImmJ;
            default:        sel = ImmI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal
);

    ctrl_state_e state_q, state_d;
    ctrl_state_e dispatch_state;
    logic        dispatch_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        dispatch_state = StFetch;
        dispatch_bad   = 1'b0;
        case (opcode)
            OpLoad, OpStore: dispatch_state = StMemAdr;
            OpReg:           dispatch_state = StExecR;
            OpImm:           dispatch_state = StExecI;
            OpBranch: begin
                dispatch_state = StBranch;
                dispatch_bad   = !branch_f3_legal(funct3);
            end
            OpJal:           dispatch_state = StJal;
            OpJalr:          dispatch_state = StJalr;
            OpLui:           dispatch_state = StLui;
            OpAuipc:         dispatch_state = StAuipc;
            OpFence:         dispatch_state = StFetch;
            default:         dispatch_bad   = 1'b1;
        endcase
    end

    assign imm_src = imm_sel(opcode);

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        result_src = ResAluOut;
        alu_op     = AluOpAdd;
        retire     = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Precompute the branch/JAL target into alu_out.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                if (dispatch_bad) begin
                    if (TRAP_ON_ILLEGAL) begin
                        state_d = StTrap;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    retire  = (dispatch_state == StFetch);
                    state_d = dispatch_state;
                end
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpBranch;
                pc_write  = branch_taken(funct3, zero, alu_lsb);
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                // PC takes the target from alu_out while the ALU forms old_pc+4.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                result_src = ResAlu;
                pc_write   = 1'b1;
                state_d    = StJalrLink;
            end
            StJalrLink: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                state_d   = StAluWb;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                state_d   = StAluWb;
            end
            StTrap: illegal = 1'b1;
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: vector table, directed corner
// sequences and randomized instructions against an instruction-level model.
module tb_rv_multicycle_ctrl;

    typedef struct packed {
        logic       rdy;
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [2:0] imm;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } snap_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       l;
        int         cyc;
        int         pcw;
        int         rgw;
        logic [2:0] imm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, alu_lsb, mem_ready;

    logic       d_mem_req, d_mem_we, d_adr_src, d_ir_write, d_pc_write, d_reg_write;
    logic [1:0] d_src_a, d_src_b, d_res, d_alu_op;
    logic [2:0] d_imm;
    logic       d_retire, d_illegal;

    logic       n_mem_req, n_mem_we, n_adr_src, n_ir_write, n_pc_write, n_reg_write;
    logic [1:0] n_src_a, n_src_b, n_res, n_alu_op;
    logic [2:0] n_imm;
    logic       n_retire, n_illegal;

    int    checks = 0;
    int    errors = 0;
    snap_t trace[64];
    int    tlen;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .alu_lsb(alu_lsb), .mem_ready(mem_ready), .mem_req(d_mem_req), .mem_we(d_mem_we),
        .adr_src(d_adr_src), .ir_write(d_ir_write), .pc_write(d_pc_write),
        .reg_write(d_reg_write), .alu_src_a(d_src_a), .alu_src_b(d_src_b),
        .result_src(d_res), .imm_src(d_imm), .alu_op(d_alu_op), .retire(d_retire),
        .illegal(d_illegal)
    );

    rv_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .alu_lsb(alu_lsb), .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_we(n_mem_we),
        .adr_src(n_adr_src), .ir_write(n_ir_write), .pc_write(n_pc_write),
        .reg_write(n_reg_write), .alu_src_a(n_src_a), .alu_src_b(n_src_b),
        .result_src(n_res), .imm_src(n_imm), .alu_op(n_alu_op), .retire(n_retire),
        .illegal(n_illegal)
    );

    function automatic snap_t take();
        return '{mem_ready, d_mem_req, d_mem_we, d_adr_src, d_ir_write, d_pc_write,
                 d_reg_write, d_src_a, d_src_b, d_res, d_imm, d_alu_op, d_retire, d_illegal};
    endfunction

    function automatic snap_t take_nop();
        return '{mem_ready, n_mem_req, n_mem_we, n_adr_src, n_ir_write, n_pc_write,
                 n_reg_write, n_src_a, n_src_b, n_res, n_imm, n_alu_op, n_retire, n_illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench 1ns after the edge that enters the first FETCH.
    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Memory responder stalls wf cycles on the fetch and wm on the data access.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input logic l, input int wf, input int wm, output int ncyc);
        int    remaining, phase, lockstep_bad;
        logic  done;
        opcode = op; funct3 = f3; zero = z; alu_lsb = l;
        remaining = wf; phase = 0; done = 1'b0; ncyc = 0; lockstep_bad = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            if (d_mem_req) begin
                if (remaining > 0) remaining--;
                else mem_ready = 1'b1;
            end
            #1;
            trace[c] = take();
            if (take_nop() != trace[c]) lockstep_bad++;
            ncyc = c + 1;
            if (d_mem_req && mem_ready) begin
                phase++;
                remaining = wm;
            end
            if (d_retire) done = 1'b1;
        end
        tlen = ncyc;
        chk("retired_in_budget", done, 1);
        chk("param_lockstep", lockstep_bad, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic evaluate(input string tag, input int e_cyc, input int e_pc, input int e_rg,
                            input int e_mr, input int e_we);
        int pc = 0, rg = 0, ir = 0, mr = 0, we = 0, rt = 0, unstable = 0;
        for (int i = 0; i < tlen; i++) begin
            pc += trace[i].pc_write;
            rg += trace[i].reg_write;
            ir += trace[i].ir_write;
            mr += trace[i].mem_req;
            we += trace[i].mem_we;
            rt += trace[i].retire;
            if (i > 0 && trace[i].mem_req && trace[i-1].mem_req && !trace[i-1].rdy &&
                (trace[i].adr_src != trace[i-1].adr_src || trace[i].mem_we != trace[i-1].mem_we))
                unstable++;
        end
        chk({tag, "_cycles"}, tlen, e_cyc);
        chk({tag, "_pc_write"}, pc, e_pc);
        chk({tag, "_reg_write"}, rg, e_rg);
        chk({tag, "_ir_write"}, ir, 1);
        chk({tag, "_mem_req"}, mr, e_mr);
        chk({tag, "_mem_we"}, we, e_we);
        chk({tag, "_retire"}, rt, 1);
        chk({tag, "_req_stable"}, unstable, 0);
    endtask

    // Instruction-level model: counts per instruction class, not per state.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input logic l, input int wf, input int wm, output int e_cyc,
                         output int e_pc, output int e_rg, output int e_mr, output int e_we);
        logic taken;
        int   base, extra_pc, rg;
        logic is_ld, is_st;
        case (f3)
            3'd0: taken = z;
            3'd1: taken = !z;
            3'd4, 3'd6: taken = l;
            default: taken = !l;
        endcase
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        extra_pc = 0;
        rg = 1;
        case (op)
            7'b0000011, 7'b1100111: base = 5;
            7'b1100011: begin base = 3; rg = 0; extra_pc = int'(taken); end
            7'b0001111: begin base = 2; rg = 0; end
            7'b0100011: begin base = 4; rg = 0; end
            default: base = 4;
        endcase
        if (op == 7'b1101111 || op == 7'b1100111) extra_pc = 1;
        e_cyc = base + wf + ((is_ld || is_st) ? wm : 0);
        e_pc  = 1 + extra_pc;
        e_rg  = rg;
        e_mr  = 1 + wf + ((is_ld || is_st) ? 1 + wm : 0);
        e_we  = is_st ? 1 + wm : 0;
    endtask

    initial begin
        vec_t       vecs[13];
        logic [6:0] rops[10];
        logic [2:0] bf3[6];
        snap_t      s, exp_trap;
        int         n, cnt;
        int         e_cyc, e_pc, e_rg, e_mr, e_we;

        vecs[0]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 1, 1, 3'b000};
        vecs[1]  = '{7'b0010011, 3'd0, 1'b0, 1'b0, 4, 1, 1, 3'b000};
        vecs[2]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 1, 1, 3'b000};
        vecs[3]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 1, 0, 3'b001};
        vecs[4]  = '{7'b1100011, 3'd0, 1'b1, 1'b0, 3, 2, 0, 3'b010};
        vecs[5]  = '{7'b1100011, 3'd1, 1'b1, 1'b0, 3, 1, 0, 3'b010};
        vecs[6]  = '{7'b1100011, 3'd7, 1'b0, 1'b0, 3, 2, 0, 3'b010};
        vecs[7]  = '{7'b1100011, 3'd4, 1'b0, 1'b0, 3, 1, 0, 3'b010};
        vecs[8]  = '{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 2, 1, 3'b100};
        vecs[9]  = '{7'b1100111, 3'd0, 1'b0, 1'b0, 5, 2, 1, 3'b000};
        vecs[10] = '{7'b0110111, 3'd0, 1'b0, 1'b0, 4, 1, 1, 3'b011};
        vecs[11] = '{7'b0010111, 3'd0, 1'b0, 1'b0, 4, 1, 1, 3'b011};
        vecs[12] = '{7'b0001111, 3'd0, 1'b0, 1'b0, 2, 1, 0, 3'b000};
        rops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", take(), 0);
        rst = 1'b0;
        #1 chk("idle_outputs", take(), 0);
        @(posedge clk); #1;
        chk("first_fetch_req", d_mem_req, 1);
        chk("first_fetch_adr", d_adr_src, 0);

        // add with zero-wait memory
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, n);
        chk("add_c1_ir_write", trace[0].ir_write, 1);
        chk("add_c1_pc_write", trace[0].pc_write, 1);
        chk("add_c3_alu_op", trace[2].alu_op, 2'b10);
        chk("add_c3_src_b", trace[2].src_b, 2'b00);
        chk("add_c4_reg_write", trace[3].reg_write, 1);
        chk("add_c4_retire", trace[3].retire, 1);
        evaluate("add", 4, 1, 1, 1, 0);

        // lw with three stall cycles on both memory accesses
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3, 3, n);
        cnt = 0;
        for (int i = 0; i < tlen; i++) cnt += int'(trace[i].reg_write && trace[i].res == 2'b01);
        chk("lw_wait_data_wb_once", cnt, 1);
        evaluate("lw_wait", 11, 1, 1, 8, 0);

        // jalr stage by stage
        run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0, n);
        chk("jalr_pc_write", trace[2].pc_write, 1);
        chk("jalr_result_src", trace[2].res, 2'b10);
        chk("jalr_src_a", trace[2].src_a, 2'b10);
        chk("jalr_link_src_a", trace[3].src_a, 2'b01);
        chk("jalr_link_src_b", trace[3].src_b, 2'b10);
        chk("jalr_wb_reg_write", trace[4].reg_write, 1);
        evaluate("jalr", 5, 2, 1, 1, 0);

        // rst asserted while MEMREAD is stalled
        opcode = 7'b0000011; funct3 = 3'd2;
        mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("memread_req", d_mem_req, 1);
        chk("memread_adr", d_adr_src, 1);
        rst = 1'b1;
        #1 chk("rst_async_outputs", take(), 0);
        @(posedge clk); #1;
        chk("rst_held_outputs", take(), 0);
        rst = 1'b0;
        #1 chk("post_rst_idle", take(), 0);
        @(posedge clk); #1;
        chk("post_rst_fetch_req", d_mem_req, 1);
        chk("post_rst_fetch_adr", d_adr_src, 0);

        for (int v = 0; v < 13; v++) begin
            run_instr(vecs[v].op, vecs[v].f3, vecs[v].z, vecs[v].l, 0, 0, n);
            chk($sformatf("vec%0d_cycles", v), n, vecs[v].cyc);
            cnt = 0;
            for (int i = 0; i < tlen; i++) cnt += trace[i].pc_write;
            chk($sformatf("vec%0d_pc_write", v), cnt, vecs[v].pcw);
            cnt = 0;
            for (int i = 0; i < tlen; i++) cnt += trace[i].reg_write;
            chk($sformatf("vec%0d_reg_write", v), cnt, vecs[v].rgw);
            chk($sformatf("vec%0d_imm_src", v), trace[1].imm, vecs[v].imm);
            if (vecs[v].op == 7'b1100011) begin
                chk($sformatf("vec%0d_br_pc_write", v), trace[2].pc_write, vecs[v].pcw - 1);
                chk($sformatf("vec%0d_br_retire", v), trace[2].retire, 1);
            end
        end

        for (int k = 0; k < 60; k++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       z, l;
            int         wf, wm;
            op = rops[$urandom_range(0, 9)];
            f3 = (op == 7'b1100011) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            z  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            model(op, f3, z, l, wf, wm, e_cyc, e_pc, e_rg, e_mr, e_we);
            run_instr(op, f3, z, l, wf, wm, n);
            evaluate($sformatf("rnd%0d_op%02h", k, op), e_cyc, e_pc, e_rg, e_mr, e_we);
        end

        // Illegal opcode: one instance traps, the other retires and moves on.
        opcode = 7'b1110011; funct3 = 3'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("nop_illegal_retire", n_retire, 1);
        @(posedge clk); #1;
        chk("trap_illegal", d_illegal, 1);
        chk("nop_next_fetch", n_mem_req, 1);
        chk("nop_not_illegal", n_illegal, 0);
        exp_trap = '0;
        exp_trap.illegal = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            s = take();
            s.rdy = 1'b0;
            if (s != exp_trap) cnt++;
        end
        chk("trap_sticky_20", cnt, 0);

        do_reset();
        chk("trap_cleared", d_illegal, 0);
        opcode = 7'b1100011; funct3 = 3'd2; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("nop_bad_branch_retire", n_retire, 1);
        @(posedge clk); #1;
        chk("bad_branch_trap", d_illegal, 1);
        chk("bad_branch_no_req", d_mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
